// File: rtl/mining_pkg.sv
// Shared widths, FSM encoding and hash slicing helper for the nonce search controller.
package mining_pkg;

  localparam int DEF_HDR_BYTES    = 12;
  localparam int DEF_NONCE_BYTES  = 4;
  localparam int DEF_HASH_BYTES   = 3;
  localparam int DEF_TARGET_BYTES = 1;

  // Widest hash the slicing helper can handle; narrower hashes are zero-extended.
  localparam int SLICE_MAX_W = 64;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_CHECK,
    S_DRAIN,
    S_DONE
  } state_t;

  function automatic int nonce_width(input int nonce_bytes);
    return 8 * nonce_bytes;
  endfunction

  // Keeps only the top target_bytes bytes of a hash, right-aligned.
  function automatic logic [SLICE_MAX_W-1:0] top_hash_bytes(
    input logic [SLICE_MAX_W-1:0] hash,
    input int                     hash_bytes,
    input int                     target_bytes
  );
    return hash >> (8 * (hash_bytes - target_bytes));
  endfunction

endpackage

// File: rtl/hash_target_cmp.sv
// Combinational difficulty check: top bytes of the hash strictly below the target.
module hash_target_cmp
  import mining_pkg::*;
#(
  parameter int HASH_BYTES   = DEF_HASH_BYTES,
  parameter int TARGET_BYTES = DEF_TARGET_BYTES
) (
  input  logic [8*HASH_BYTES-1:0]   hash,
  input  logic [8*TARGET_BYTES-1:0] target,
  output logic                      hit
);

  logic [SLICE_MAX_W-1:0] sliced;

  // Upper bits of the slice are zero, so a full-width compare equals the narrow one.
  assign sliced = top_hash_bytes(SLICE_MAX_W'(hash), HASH_BYTES, TARGET_BYTES);
  assign hit    = sliced < SLICE_MAX_W'(target);

endmodule

// File: rtl/nonce_search_ctrl.sv
// Nonce sweep engine: issues one header+nonce request at a time, checks each hash
// against the target and stops on the first hit or at the end of the range.
module nonce_search_ctrl
  import mining_pkg::*;
#(
  parameter int HDR_BYTES     = DEF_HDR_BYTES,
  parameter int NONCE_BYTES   = DEF_NONCE_BYTES,
  parameter int HASH_BYTES    = DEF_HASH_BYTES,
  parameter int TARGET_BYTES  = DEF_TARGET_BYTES,
  parameter int STOP_ON_FIRST = 1,
  localparam int NONCE_W      = nonce_width(NONCE_BYTES)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      abort,
  input  logic [8*HDR_BYTES-1:0]    header_in,
  input  logic [NONCE_W-1:0]        nonce_first,
  input  logic [NONCE_W-1:0]        nonce_last,
  input  logic [8*TARGET_BYTES-1:0] target_in,
  output logic                      hc_valid,
  input  logic                      hc_ready,
  output logic [8*HDR_BYTES-1:0]    hc_header,
  output logic [NONCE_W-1:0]        hc_nonce,
  input  logic                      hash_valid,
  input  logic [8*HASH_BYTES-1:0]   hash_in,
  output logic                      busy,
  output logic                      done,
  output logic                      found,
  output logic                      aborted,
  output logic [NONCE_W-1:0]        found_nonce,
  output logic [NONCE_W:0]          hit_count,
  output logic [NONCE_W:0]          attempts
);

  localparam logic [NONCE_W:0]   CNT_ONE   = (NONCE_W + 1)'(1);
  localparam logic [NONCE_W-1:0] NONCE_ONE = NONCE_W'(1);

  state_t                    state;
  logic [NONCE_W-1:0]        nonce_end;
  logic [8*TARGET_BYTES-1:0] target;
  logic [8*HASH_BYTES-1:0]   hash_q;
  logic                      hit;

  hash_target_cmp #(
    .HASH_BYTES  (HASH_BYTES),
    .TARGET_BYTES(TARGET_BYTES)
  ) u_cmp (
    .hash  (hash_q),
    .target(target),
    .hit   (hit)
  );

  assign busy = (state != S_IDLE);

  // done is raised on every transition into DONE, so it is high exactly while in DONE.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= S_IDLE;
      hc_valid    <= 1'b0;
      hc_header   <= '0;
      hc_nonce    <= '0;
      nonce_end   <= '0;
      target      <= '0;
      hash_q      <= '0;
      done        <= 1'b0;
      found       <= 1'b0;
      aborted     <= 1'b0;
      found_nonce <= '0;
      hit_count   <= '0;
      attempts    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            hc_header   <= header_in;
            hc_nonce    <= nonce_first;
            nonce_end   <= nonce_last;
            target      <= target_in;
            found       <= 1'b0;
            aborted     <= 1'b0;
            found_nonce <= '0;
            hit_count   <= '0;
            attempts    <= '0;
            hc_valid    <= 1'b1;
            state       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (hc_ready) begin
            hc_valid <= 1'b0;
            if (abort) begin
              aborted <= 1'b1;
              state   <= S_DRAIN;
            end else begin
              state <= S_WAIT;
            end
          end else if (abort) begin
            hc_valid <= 1'b0;
            aborted  <= 1'b1;
            done     <= 1'b1;
            state    <= S_DONE;
          end
        end
        S_WAIT: begin
          if (hash_valid) begin
            if (abort) begin
              aborted <= 1'b1;
              done    <= 1'b1;
              state   <= S_DONE;
            end else begin
              hash_q <= hash_in;
              state  <= S_CHECK;
            end
          end else if (abort) begin
            aborted <= 1'b1;
            state   <= S_DRAIN;
          end
        end
        S_CHECK: begin
          attempts <= attempts + CNT_ONE;
          if (hit) begin
            hit_count <= hit_count + CNT_ONE;
            if (!found) begin
              found       <= 1'b1;
              found_nonce <= hc_nonce;
            end
          end
          if (abort) begin
            aborted <= 1'b1;
            done    <= 1'b1;
            state   <= S_DONE;
          end else if ((hit && (STOP_ON_FIRST != 0)) || (hc_nonce == nonce_end)) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            hc_nonce <= hc_nonce + NONCE_ONE;
            hc_valid <= 1'b1;
            state    <= S_ISSUE;
          end
        end
        S_DRAIN: begin
          if (hash_valid) begin
            done  <= 1'b1;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nonce_search_ctrl.sv
// Directed bench for nonce_search_ctrl: one stop-on-first instance and one full-sweep
// instance, each fed by a small hash-core model with hand-computed expected results.
module tb_nonce_search_ctrl;

  logic          clk;
  logic          reset;
  logic          abort;
  logic [95:0]   header_in;
  logic [31:0]   nonce_first;
  logic [31:0]   nonce_last;
  logic [7:0]    target_in;

  logic          start1, ready1, hv1;
  logic [23:0]   hash1;
  logic          v1, busy1, done1, found1, ab1;
  logic [95:0]   hc1;
  logic [31:0]   n1, fn1;
  logic [32:0]   hitc1, at1;

  logic          start0, ready0, hv0;
  logic [23:0]   hash0;
  logic          v0, busy0, done0, found0, ab0;
  logic [95:0]   hc0;
  logic [31:0]   n0, fn0;
  logic [32:0]   hitc0, at0;

  int            total;
  int            bad;
  logic [31:0]   issued[$];
  logic [95:0]   cur_header;
  bit            got_done;

  nonce_search_ctrl #(.STOP_ON_FIRST(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .abort(abort),
    .header_in(header_in), .nonce_first(nonce_first), .nonce_last(nonce_last),
    .target_in(target_in), .hc_valid(v1), .hc_ready(ready1), .hc_header(hc1),
    .hc_nonce(n1), .hash_valid(hv1), .hash_in(hash1), .busy(busy1), .done(done1),
    .found(found1), .aborted(ab1), .found_nonce(fn1), .hit_count(hitc1), .attempts(at1)
  );

  nonce_search_ctrl #(.STOP_ON_FIRST(0)) dut0 (
    .clk(clk), .reset(reset), .start(start0), .abort(abort),
    .header_in(header_in), .nonce_first(nonce_first), .nonce_last(nonce_last),
    .target_in(target_in), .hc_valid(v0), .hc_ready(ready0), .hc_header(hc0),
    .hc_nonce(n0), .hash_valid(hv0), .hash_in(hash0), .busy(busy0), .done(done0),
    .found(found0), .aborted(ab0), .found_nonce(fn0), .hit_count(hitc0), .attempts(at0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case a bounded loop is somehow bypassed.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  // Outputs are sampled 1 time unit after the rising edge, inputs driven at the same point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Hash core model; top byte of the result is what gets compared with the target.
  function automatic logic [23:0] modelHash(input int mode, input logic [31:0] n);
    case (mode)
      0:       return 24'h12abcd;
      2:       return (n == 32'h0) ? 24'h05abcd : 24'h801234;
      3:       return (n == 32'd2 || n == 32'd5) ? 24'h0fffff : 24'h100000;
      default: return 24'h801234;
    endcase
  endfunction

  // Runs one complete sweep on the selected instance with hc_ready held high and each
  // hash returned two cycles after acceptance. Inputs are scrambled right after start
  // so any failure to latch them shows up in the results.
  task automatic applyStimulus(input bit sel, input logic [31:0] first, input logic [31:0] last,
                               input logic [7:0] tgt, input int mode);
    int          pend;
    logic [31:0] acc;
    logic [31:0] snap;
    logic        will;
    logic        hv;
    logic [23:0] hin;
    issued.delete();
    header_in   = cur_header;
    nonce_first = first;
    nonce_last  = last;
    target_in   = tgt;
    if (sel) start1 = 1'b1; else start0 = 1'b1;
    tick();
    start1      = 1'b0;
    start0      = 1'b0;
    header_in   = ~cur_header;
    nonce_first = '0;
    nonce_last  = '0;
    target_in   = ~tgt;
    pend        = -1;
    acc         = '0;
    got_done    = 1'b0;
    for (int cyc = 0; cyc < 300 && !got_done; cyc++) begin
      hin = 24'h0;
      if (pend == 0) begin
        hv   = 1'b1;
        hin  = modelHash(mode, acc);
        pend = -1;
      end else begin
        hv = 1'b0;
        if (pend > 0) pend--;
      end
      if (sel) begin hv1 = hv; hash1 = hin; ready1 = 1'b1; end
      else     begin hv0 = hv; hash0 = hin; ready0 = 1'b1; end
      will = sel ? v1 : v0;
      snap = sel ? n1 : n0;
      tick();
      if (will) begin
        issued.push_back(snap);
        acc  = snap;
        pend = 1;
      end
      if (sel ? done1 : done0) got_done = 1'b1;
    end
    hv1 = 1'b0; hv0 = 1'b0; ready1 = 1'b0; ready0 = 1'b0;
    checkOutput("sweep_done_seen", 128'(got_done), 128'(1'b1));
    tick();
  endtask

  initial begin
    total = 0;
    bad = 0;
    reset = 1'b0; abort = 1'b0;
    header_in = '0; nonce_first = '0; nonce_last = '0; target_in = '0;
    start1 = 1'b0; ready1 = 1'b0; hv1 = 1'b0; hash1 = '0;
    start0 = 1'b0; ready0 = 1'b0; hv0 = 1'b0; hash0 = '0;
    cur_header = 96'h397d9f2f40ca9e6c6b1f3324;

    // Reset state
    tick(); tick();
    checkOutput("rst_hc_valid", 128'(v1), 128'(1'b0));
    checkOutput("rst_busy", 128'(busy1), 128'(1'b0));
    checkOutput("rst_done", 128'(done1), 128'(1'b0));
    checkOutput("rst_found", 128'(found1), 128'(1'b0));
    checkOutput("rst_attempts", 128'(at1), 128'(0));
    checkOutput("rst_hc_nonce", 128'(n1), 128'(0));
    checkOutput("rst_busy0", 128'(busy0), 128'(1'b0));
    reset = 1'b1;
    tick();

    // Single-nonce range with a hit
    applyStimulus(1'b1, 32'hfded873c, 32'hfded873c, 8'hff, 0);
    checkOutput("t1_num_req", 128'(issued.size()), 128'(1));
    checkOutput("t1_req_nonce", 128'(issued[0]), 128'(32'hfded873c));
    checkOutput("t1_found", 128'(found1), 128'(1'b1));
    checkOutput("t1_found_nonce", 128'(fn1), 128'(32'hfded873c));
    checkOutput("t1_attempts", 128'(at1), 128'(1));
    checkOutput("t1_hit_count", 128'(hitc1), 128'(1));
    checkOutput("t1_header_latched", 128'(hc1), 128'(96'h397d9f2f40ca9e6c6b1f3324));
    checkOutput("t1_idle", 128'(busy1), 128'(1'b0));

    // Target zero never hits
    cur_header = 96'h0123456789abcdef01234567;
    applyStimulus(1'b1, 32'h10, 32'h13, 8'h00, 0);
    checkOutput("t2_num_req", 128'(issued.size()), 128'(4));
    for (int i = 0; i < 4; i++)
      checkOutput($sformatf("t2_req_nonce%0d", i), 128'(issued[i]), 128'(32'h10 + 32'(i)));
    checkOutput("t2_found", 128'(found1), 128'(1'b0));
    checkOutput("t2_hit_count", 128'(hitc1), 128'(0));
    checkOutput("t2_attempts", 128'(at1), 128'(4));

    // Wrap-around range, stop on the hit at nonce 0
    applyStimulus(1'b1, 32'hfffffffe, 32'h00000001, 8'h10, 2);
    checkOutput("t3_num_req", 128'(issued.size()), 128'(3));
    checkOutput("t3_req0", 128'(issued[0]), 128'(32'hfffffffe));
    checkOutput("t3_req1", 128'(issued[1]), 128'(32'hffffffff));
    checkOutput("t3_req2", 128'(issued[2]), 128'(32'h0));
    checkOutput("t3_found_nonce", 128'(fn1), 128'(32'h0));
    checkOutput("t3_attempts", 128'(at1), 128'(3));
    checkOutput("t3_hit_count", 128'(hitc1), 128'(1));

    // Full sweep counting hits; hash byte equal to target is not a hit
    applyStimulus(1'b0, 32'h0, 32'h7, 8'h10, 3);
    checkOutput("t4_num_req", 128'(issued.size()), 128'(8));
    checkOutput("t4_attempts", 128'(at0), 128'(8));
    checkOutput("t4_hit_count", 128'(hitc0), 128'(2));
    checkOutput("t4_found_nonce", 128'(fn0), 128'(32'd2));
    checkOutput("t4_found", 128'(found0), 128'(1'b1));
    checkOutput("t4_aborted", 128'(ab0), 128'(1'b0));

    // Backpressure: request held stable while hc_ready is low
    nonce_first = 32'd100; nonce_last = 32'd100; target_in = 8'hff;
    header_in = cur_header;
    start1 = 1'b1; ready1 = 1'b0;
    tick();
    start1 = 1'b0;
    checkOutput("t5_valid_start", 128'(v1), 128'(1'b1));
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput($sformatf("t5_valid_%0d", i), 128'(v1), 128'(1'b1));
      checkOutput($sformatf("t5_nonce_%0d", i), 128'(n1), 128'(32'd100));
      checkOutput($sformatf("t5_attempts_%0d", i), 128'(at1), 128'(0));
    end
    ready1 = 1'b1;
    tick();
    ready1 = 1'b0;
    checkOutput("t5_valid_drop", 128'(v1), 128'(1'b0));
    tick();
    hv1 = 1'b1; hash1 = 24'h120000;
    tick();
    hv1 = 1'b0;
    tick();
    checkOutput("t5_done", 128'(done1), 128'(1'b1));
    checkOutput("t5_attempts_end", 128'(at1), 128'(1));
    tick();

    // Abort in ISSUE before acceptance
    nonce_first = 32'd500; nonce_last = 32'd505;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checkOutput("ta_valid", 128'(v1), 128'(1'b0));
    checkOutput("ta_done", 128'(done1), 128'(1'b1));
    checkOutput("ta_aborted", 128'(ab1), 128'(1'b1));
    checkOutput("ta_attempts", 128'(at1), 128'(0));
    tick();

    // Abort in WAIT, hash arrives later and is discarded
    nonce_first = 32'd200; nonce_last = 32'd205;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    ready1 = 1'b1;
    tick();
    ready1 = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checkOutput("t6_busy_drain", 128'(busy1), 128'(1'b1));
    checkOutput("t6_aborted", 128'(ab1), 128'(1'b1));
    checkOutput("t6_no_done_0", 128'(done1), 128'(1'b0));
    tick();
    tick();
    checkOutput("t6_no_done_1", 128'(done1), 128'(1'b0));
    hv1 = 1'b1; hash1 = 24'h120000;
    tick();
    hv1 = 1'b0;
    checkOutput("t6_done", 128'(done1), 128'(1'b1));
    checkOutput("t6_attempts", 128'(at1), 128'(0));
    checkOutput("t6_hit_count", 128'(hitc1), 128'(0));
    tick();
    checkOutput("t6_done_pulse", 128'(done1), 128'(1'b0));
    checkOutput("t6_idle", 128'(busy1), 128'(1'b0));

    // Reset mid-sweep, then a late hash, then a clean sweep
    nonce_first = 32'd300; nonce_last = 32'd310;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    ready1 = 1'b1;
    tick();
    ready1 = 1'b0;
    reset = 1'b0;
    tick();
    checkOutput("t7_valid", 128'(v1), 128'(1'b0));
    checkOutput("t7_busy", 128'(busy1), 128'(1'b0));
    checkOutput("t7_nonce", 128'(n1), 128'(0));
    checkOutput("t7_header", 128'(hc1), 128'(0));
    checkOutput("t7_found0_cleared", 128'(found0), 128'(1'b0));
    checkOutput("t7_hitc0_cleared", 128'(hitc0), 128'(0));
    reset = 1'b1;
    hv1 = 1'b1; hash1 = 24'h120000;
    tick();
    hv1 = 1'b0;
    tick();
    checkOutput("t7_late_hash_busy", 128'(busy1), 128'(1'b0));
    checkOutput("t7_late_hash_attempts", 128'(at1), 128'(0));
    applyStimulus(1'b1, 32'd400, 32'd401, 8'hff, 0);
    checkOutput("t7_num_req", 128'(issued.size()), 128'(1));
    checkOutput("t7_found_nonce", 128'(fn1), 128'(32'd400));
    checkOutput("t7_attempts", 128'(at1), 128'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nonce_search_ctrl.md
Name: nonce_search_ctrl

Overview:
Synthesizable nonce-sweep controller for the mining datapath. It takes a block header, a nonce range and a difficulty target, then issues one header+nonce request at a time to the hash core. Each returned hash is checked against the target; the block stops on the first hit or sweeps the whole range and counts hits. Replaces hand-driven header/nonce/target stimulus with a parametrised, handshaked engine.

Parameters:
HDR_BYTES, 12, header width in bytes
NONCE_BYTES, 4, nonce width in bytes (NONCE_W = 8*NONCE_BYTES)
HASH_BYTES, 3, hash result width in bytes from the hash core
TARGET_BYTES, 1, target width in bytes; must be <= HASH_BYTES
STOP_ON_FIRST, 1, 1 = finish on first hit; 0 = sweep full range and count hits

Ports:
clk  in  1  single clock; all logic on posedge
reset  in  1  synchronous, active-low reset
start  in  1  one-cycle request to begin a sweep; sampled only in IDLE
abort  in  1  stop the current sweep
header_in  in  8*HDR_BYTES  block header, latched at start
nonce_first  in  NONCE_W  first nonce, latched at start
nonce_last  in  NONCE_W  last nonce (inclusive), latched at start
target_in  in  8*TARGET_BYTES  difficulty target, latched at start
hc_valid  out  1  request valid to the hash core
hc_ready  in  1  hash core accepts the request
hc_header  out  8*HDR_BYTES  latched header
hc_nonce  out  NONCE_W  current nonce
hash_valid  in  1  one-cycle strobe: hash_in is valid
hash_in  in  8*HASH_BYTES  hash result
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at sweep end
found  out  1  at least one hit in the last sweep
aborted  out  1  last sweep ended by abort
found_nonce  out  NONCE_W  nonce of the first hit
hit_count  out  NONCE_W+1  number of hits in the last sweep
attempts  out  NONCE_W+1  number of hashes checked in the last sweep

Behaviour:
- Reset (reset==0 at posedge): state=IDLE; every output is 0, including hc_valid and the latched registers. Reset mid-sweep discards everything. A hash_valid that arrives after reset is ignored.
- FSM states: IDLE, ISSUE, WAIT, CHECK, DRAIN, DONE.
- IDLE: on start, latch the inputs, set nonce=nonce_first, and clear found, aborted, found_nonce, hit_count and attempts; then go to ISSUE. Results from the previous sweep are held until the next start.
- ISSUE: hc_valid=1. hc_header and hc_nonce stay stable until the cycle hc_valid&&hc_ready; then go to WAIT. hc_valid drops the cycle after acceptance.
- Only one request is outstanding at a time.
- WAIT: on hash_valid, register the hash, then go to CHECK. hash_valid in any other state is ignored, except in DRAIN.
- CHECK (one cycle): attempts+=1. A hit means the top TARGET_BYTES bytes of the hash are strictly below target_in, unsigned. So target 0 never hits.
- On a hit: hit_count+=1; if found==0, set found=1 and found_nonce=nonce.
- Next state after CHECK:
  - hit and STOP_ON_FIRST: DONE
  - nonce==nonce_last: DONE
  - otherwise: nonce+=1 (mod 2^NONCE_W), then ISSUE
- Range rules: nonce_first > nonce_last is a wrap-around sweep through all-ones to 0. nonce_first == nonce_last is exactly one attempt. A full range gives attempts = 2^NONCE_W; the counter is NONCE_W+1 bits wide, so it never overflows.
- Abort handling:
  - In ISSUE before acceptance: go to DONE next cycle and drop hc_valid; no request is lost.
  - In WAIT: go to DRAIN.
  - In CHECK: finish the check, then go to DONE.
  - All three cases set aborted=1.
  - In IDLE or DONE, abort is ignored.
- DRAIN: wait for hash_valid and discard the hash (not counted); then go to DONE.
- Simultaneous abort and hc_ready in ISSUE: the request counts as accepted, so go to DRAIN.
- Simultaneous abort and hash_valid in WAIT: discard the hash and go to DONE.
- DONE: done=1 for one cycle, then IDLE. start in any state other than IDLE is ignored.

Decomposition:
- Package mining_pkg:
  - byte-width localparams and the NONCE_W derivation
  - FSM state enum
  - a function that slices the top TARGET_BYTES bytes out of a hash
- One natural sub-module, hash_target_cmp: combinational unsigned compare of the sliced hash against the target, parametrised by HASH_BYTES and TARGET_BYTES.

Test Plan:
1. header {39,7d,9f,2f,40,ca,9e,6c,6b,1f,33,24}, nonce_first=nonce_last=32'hfded873c, target 8'hff, model hash 24'h12xxxx -> one request carrying hc_nonce=fded873c; then done pulse, found=1, found_nonce=fded873c, attempts=1, hit_count=1.
2. target 8'h00, range 0x10..0x13 -> 4 requests with nonces 10,11,12,13; found=0, hit_count=0, attempts=4.
3. STOP_ON_FIRST=1, range 32'hFFFFFFFE..32'h00000001, model hits only at nonce 0 -> nonces FFFFFFFE, FFFFFFFF, 0 are issued; done, found_nonce=0, attempts=3; nonce 1 is never issued.
4. STOP_ON_FIRST=0, range 0..7, model hits at nonces 2 and 5 -> attempts=8, hit_count=2, found_nonce=2.
5. Backpressure: hc_ready held low for 5 cycles -> hc_valid stays high with hc_nonce stable; attempts does not advance.
6. abort asserted in WAIT, hash returned 3 cycles later -> DRAIN; done pulses 1 cycle after hash_valid; aborted=1, attempts unchanged. Separately, reset low mid-sweep -> next cycle all outputs 0; a new start then completes normally.
